// File: rtl/signed_div_pkg.sv
// signed_div_pkg: shared state encoding, default width and magnitude helper for the signed divider.
package signed_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic logic [15:0] abs_u(input logic [15:0] x, input int width);
    logic [15:0] m;
    m = 16'((32'd1 << width) - 32'd1);
    return x[width-1] ? (~x + 16'd1) & m : x & m;
  endfunction
endpackage

// File: rtl/eight_bit_adder.sv
// eight_bit_adder: parameterised ripple-carry adder with carry in and carry out.
module eight_bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic c;
  always_comb begin
    s = '0;
    c = ci;
    for (int k = 0; k < WIDTH; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    co = c;
  end
endmodule

// File: rtl/sequential_signed_divider_div_step.sv
// div_step: one restoring shift-subtract step on unsigned magnitudes.
module div_step
  import signed_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, trial;
  logic           no_borrow;
  assign shifted = {rem, dvd_msb};
  // Adding the inverted divisor with carry-in 1 subtracts; carry-out 1 means trial >= 0.
  eight_bit_adder #(.WIDTH(WIDTH + 1)) u_sub (
    .a (shifted),
    .b (~{1'b0, divisor}),
    .ci(1'b1),
    .s (trial),
    .co(no_borrow)
  );
  assign q_bit    = no_borrow;
  assign next_rem = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/sequential_signed_divider.sv
// sequential_signed_divider: multi-cycle restoring signed divider with start/busy/done handshake.
module sequential_signed_divider
  import signed_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic             sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;
  logic [15:0]      a_abs, b_abs;
  assign a_abs = abs_u(16'(A), WIDTH);
  assign b_abs = abs_u(16'(B), WIDTH);
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .next_rem(next_rem),
    .q_bit   (q_bit)
  );
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d    = a_abs[WIDTH-1:0];
        dvs_d    = b_abs[WIDTH-1:0];
        sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
        sign_r_d = A[WIDTH-1];
        rem_d    = '0;
        count_d  = CW'(WIDTH);
        busy_d   = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        rem_d   = next_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], q_bit};
        count_d = count_q - CW'(1);
        state_d = (count_q == CW'(1)) ? FIX : CALC;
      end
      FIX: begin
        // A zero divisor leaves q all ones; force -1 regardless of the dividend sign.
        dbz_d   = (dvs_q == '0);
        ovf_d   = sign_r_q & ~sign_q_q & (dvs_q == WIDTH'(1)) & (dvd_q == {1'b1, {(WIDTH-1){1'b0}}});
        q_out_d = dbz_d ? '1 : (sign_q_q ? -dvd_q : dvd_q);
        r_out_d = sign_r_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      q_out_q  <= q_out_d;
      r_out_q  <= r_out_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = q_out_q;
  assign R           = r_out_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_sequential_signed_divider.sv
// tb_sequential_signed_divider: table, hand-sequence, exhaustive and random checks against a truncating-division model.
module tb_sequential_signed_divider;
  localparam int W = 4;
  localparam int MINV = -(1 << (W - 1));
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic busy, done, div_by_zero, overflow;
  logic [W-1:0] Q, R;
  int n_chk = 0, n_fail = 0;

  sequential_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int q; int r; int dbz; int ovf; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return int'($signed(t));
  endfunction

  function automatic int sq(); return int'($signed(Q)); endfunction
  function automatic int sr(); return int'($signed(R)); endfunction

  task automatic model(input int a, input int b, output int q, output int r, output int dbz, output int ovf);
    dbz = (b == 0);
    ovf = (a == MINV && b == -1);
    if (dbz) begin q = -1; r = a; end
    else if (ovf) begin q = MINV; r = 0; end
    else begin q = a / b; r = a % b; end
    q = wrap(q);
    r = wrap(r);
  endtask

  // Starts one division from just after a clock edge; returns edges from accept to done (-1 on timeout).
  task automatic do_div(input int a, input int b, output int lat, output int busy_ok);
    start = 1'b1;
    A = a[W-1:0];
    B = b[W-1:0];
    lat = -1;
    busy_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (done) begin
        lat = i - 1;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
  endtask

  task automatic after_done(input string name);
    int q0, r0;
    q0 = sq();
    r0 = sr();
    @(posedge clk); #1;
    chk({name, " done pulse"}, int'(done), 0);
    chk({name, " Q hold"}, sq(), q0);
    chk({name, " R hold"}, sr(), r0);
  endtask

  task automatic run_check(input string name, input int a, input int b, input bit inv);
    int lat, bok, eq, er, edz, eov;
    model(a, b, eq, er, edz, eov);
    do_div(a, b, lat, bok);
    chk({name, " latency"}, lat, 5);
    chk({name, " busy"}, bok, 1);
    chk({name, " Q"}, sq(), eq);
    chk({name, " R"}, sr(), er);
    chk({name, " dbz"}, int'(div_by_zero), edz);
    chk({name, " ovf"}, int'(overflow), eov);
    if (inv && b != 0 && !(a == MINV && b == -1)) begin
      chk({name, " A==QB+R"}, wrap(sq() * b + sr()), a);
      chk({name, " |R|<|B|"}, int'((sr() < 0 ? -sr() : sr()) < (b < 0 ? -b : b)), 1);
      chk({name, " sign R"}, int'(sr() == 0 || ((sr() < 0) == (a < 0))), 1);
    end
    @(posedge clk); #1;
    chk({name, " single done"}, int'(done), 0);
  endtask

  initial begin
    int lat, bok, seen;
    tbl[0] = '{7, 2, 3, 1, 0, 0};
    tbl[1] = '{-7, 2, -3, -1, 0, 0};
    tbl[2] = '{7, -2, -3, 1, 0, 0};
    tbl[3] = '{-7, -2, 3, -1, 0, 0};
    tbl[4] = '{-8, -1, -8, 0, 0, 1};
    tbl[5] = '{-8, 1, -8, 0, 0, 0};
    tbl[6] = '{5, 0, -1, 5, 1, 0};
    tbl[7] = '{-5, 0, -1, -5, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst Q", int'(Q), 0);
    chk("rst R", int'(R), 0);
    chk("rst dbz", int'(div_by_zero), 0);
    chk("rst ovf", int'(overflow), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_div(tbl[i].a, tbl[i].b, lat, bok);
      chk($sformatf("tbl%0d latency", i), lat, 5);
      chk($sformatf("tbl%0d busy", i), bok, 1);
      chk($sformatf("tbl%0d Q", i), sq(), tbl[i].q);
      chk($sformatf("tbl%0d R", i), sr(), tbl[i].r);
      chk($sformatf("tbl%0d dbz", i), int'(div_by_zero), tbl[i].dbz);
      chk($sformatf("tbl%0d ovf", i), int'(overflow), tbl[i].ovf);
      after_done($sformatf("tbl%0d", i));
    end

    // start pulsed again during CALC must be ignored
    start = 1'b1; A = 4'd6; B = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; A = 4'd1; B = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    chk("ign latency", lat, 5);
    chk("ign Q", sq(), 2);
    chk("ign R", sr(), 0);
    after_done("ign");

    // reset in CALC aborts the division
    start = 1'b1; A = 4'd7; B = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort Q", int'(Q), 0);
    chk("abort R", int'(R), 0);
    chk("abort dbz", int'(div_by_zero), 0);
    chk("abort ovf", int'(overflow), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort no done", seen, 0);
    run_check("post-abort", 7, 2, 1'b1);

    for (int a = MINV; a < -MINV; a++)
      for (int b = MINV; b < -MINV; b++)
        run_check($sformatf("sweep %0d/%0d", a, b), a, b, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << W) - 1)) + MINV;
      b = int'($urandom_range(0, (1 << W) - 1)) + MINV;
      run_check($sformatf("rand %0d/%0d", a, b), a, b, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
